fibonacci_convert: RTL

Converts an unsigned integer into its 32-bit Fibonacci standard (Zeckendorf) form, with no two adjacent 1s, using one greedy subtraction step per clock. The stream encryption core drives it through the en_b_f / *_convert_done handshake. It is instantiated twice, once for the N path and once for the M path. Both instances start on the same cycle and have a fixed latency, so their done flags rise together.

---
 rtl/fibonacci_convert.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fibonacci_convert.sv
// fibonacci_convert: greedy integer -> Zeckendorf (Fibonacci standard form)
// converter. One bit is decided per clock from the top weight F(33) down to
// F(2), so every conversion takes exactly W_OUT+1 cycles regardless of value.
//
// Handshake: a rising edge on en_b_f (while not scanning) starts a conversion
// and samples value_in on that same edge; convert_done is a level that rises
// with the result on fibonacci and stays high until the next accepted start.
module fibonacci_convert #(
    parameter int W_IN   = 16,
    parameter int W_OUT  = 32,
    parameter int ACC_W  = 22,
    parameter int F_TOP  = 3524578,
    parameter int F_NEXT = 2178309
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_b_f,
    input  logic [W_IN-1:0]  value_in,
    output logic [W_OUT-1:0] fibonacci,
    output logic             convert_done,
    output logic [1:0]       dbg_state_o
);

    localparam int IDX_W = $clog2(W_OUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               en_q, en_d;       // en_b_f history for edge detect
    logic [ACC_W-1:0]   r_q, r_d;         // residual still to be encoded
    logic [ACC_W-1:0]   a_q, a_d;         // weight of the bit being decided
    logic [ACC_W-1:0]   b_q, b_d;         // next lower weight
    logic [IDX_W-1:0]   idx_q, idx_d;     // bit currently being decided
    logic [W_OUT-1:0]   s_q, s_d;         // shadow result built during scan
    logic [W_OUT-1:0]   fib_q, fib_d;     // published result
    logic               done_q, done_d;
    logic               start;

    assign start        = en_b_f & ~en_q;
    assign fibonacci    = fib_q;
    assign convert_done = done_q;
    assign dbg_state_o  = state_q;

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            r_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            s_q     <= '0;
            fib_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            r_q     <= r_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            fib_q   <= fib_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: load on start, one greedy subtraction per scan cycle,
    // publish in DONE (which may also accept a new start directly).
    always_comb begin
        state_d = state_q;
        en_d    = en_b_f;
        r_d     = r_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        s_d     = s_q;
        fib_d   = fib_q;
        done_d  = done_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    r_d     = {{(ACC_W-W_IN){1'b0}}, value_in};
                    a_d     = ACC_W'(F_TOP);
                    b_d     = ACC_W'(F_NEXT);
                    idx_d   = IDX_W'(W_OUT-1);
                    s_d     = '0;
                    done_d  = 1'b0;
                end
            end
            ST_SCAN: begin
                // Starts seen here are ignored; en_q still tracks the input.
                if (r_q >= a_q) begin
                    s_d[idx_q] = 1'b1;
                    r_d        = r_q - a_q;
                end else begin
                    s_d[idx_q] = 1'b0;
                end
                // Walk the Fibonacci ladder down: (a, b) -> (b, a - b).
                a_d = b_q;
                b_d = a_q - b_q;
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            ST_DONE: begin
                fib_d   = s_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (start) begin
                    // Accepting edge clears done and loads the next operand.
                    state_d = ST_SCAN;
                    r_d     = {{(ACC_W-W_IN){1'b0}}, value_in};
                    a_d     = ACC_W'(F_TOP);
                    b_d     = ACC_W'(F_NEXT);
                    idx_d   = IDX_W'(W_OUT-1);
                    s_d     = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
